// File: rtl/array_frame_buffer.sv
// Frame buffer: loads words into a small array until full or last, then replays
// them in order downstream before accepting the next frame.
module array_frame_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t                        state, state_nxt;
  logic [DEPTH-1:0][WIDTH-1:0]   arr;
  logic [AW-1:0]                 wr_ptr, rd_ptr;
  logic [AW:0]                   len;
  logic                          accept, take, to_drain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    accept    = 1'b0;
    take      = 1'b0;
    to_drain  = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        to_drain = accept & (in_last | (wr_ptr == AW'(DEPTH-1)));
        if (to_drain) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = ({1'b0, rd_ptr} == (len - (AW+1)'(1)));
        take      = out_ready;
        if (take && out_last) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Outputs depend only on registered state; rd_ptr sits at 0 while loading.
  assign out_data = arr[rd_ptr];
  assign count    = (state == DRAIN) ? (len - {1'b0, rd_ptr}) : {1'b0, wr_ptr};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arr    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      len    <= '0;
    end else begin
      if (accept) begin
        arr[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + AW'(1);
        if (to_drain) begin
          len    <= {1'b0, wr_ptr} + (AW+1)'(1);
          rd_ptr <= '0;
        end
      end
      if (take) begin
        if (out_last) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          len    <= '0;
        end else begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
    end
  end
endmodule

// File: doc/array_frame_buffer.md
# array_frame_buffer

Frame buffer that sits directly upstream of the indexed array reader. It accepts a stream of words over a valid/ready handshake into a small register array. When the array is full, or a word arrives marked last, it switches to drain mode. It then replays the stored words in order to the downstream stage over a second valid/ready handshake, and returns to loading after the final word is taken.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 4, array entries; power of two, >= 2
- clk  in  1  sole clock; all state changes on posedge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- in_data  in  WIDTH  word to store
- in_valid  in  1  in_data is valid this cycle
- in_last  in  1  qualifies in_data as final word of frame
- in_ready  out  1  block accepts a word this cycle
- out_data  out  WIDTH  stored word at read pointer
- out_valid  out  1  out_data is valid this cycle
- out_last  out  1  out_data is final word of frame
- out_ready  in  1  downstream takes out_data this cycle
- count  out  $clog2(DEPTH)+1  words currently held

## Operation
- States: LOAD, DRAIN. Reset state: LOAD.
- Internal state:
  - arr[DEPTH] of WIDTH bits
  - wr_ptr, rd_ptr of $clog2(DEPTH) bits
  - len of $clog2(DEPTH)+1 bits
- LOAD:
  - in_ready = 1; out_valid = 0; out_last = 0.
  - Accept = in_valid & in_ready.
  - On accept: arr[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1.
  - On accept with in_last=1 or wr_ptr==DEPTH-1: len <= wr_ptr+1; rd_ptr <= 0; state <= DRAIN.
- DRAIN:
  - in_ready = 0; in_valid, in_data and in_last are ignored.
  - out_valid = 1; out_data = arr[rd_ptr]; out_last = (rd_ptr == len-1).
  - Take = out_valid & out_ready.
  - On take without out_last: rd_ptr <= rd_ptr+1.
  - On take with out_last: wr_ptr <= 0; rd_ptr <= 0; len <= 0; state <= LOAD.
- count:
  - LOAD: equals wr_ptr, zero-extended.
  - DRAIN: equals len minus words already taken.
- Arithmetic:
  - Pointers wrap modulo DEPTH.
  - A full frame forces the transition before wr_ptr can wrap.
  - len == DEPTH is representable because len is one bit wider than the pointers.
- Array contents are not cleared between frames. Stale entries beyond len are never presented.

## Timing
- Reset values: in_ready=1 (state LOAD), out_valid=0, out_last=0, out_data=0, count=0.
- All array entries reset to 0.
- in_ready, out_valid, out_last and out_data are combinational from registered state only. There is no path from in_* or out_ready to any output.
- Load-to-drain latency: final accept at edge M gives out_valid=1 in the cycle after edge M.
- Drain-to-load turnaround: final take at edge K gives in_ready=1 in the cycle after edge K. There are no bubble cycles.
- Backpressure:
  - With out_ready=0, out_data, out_last and count hold stable indefinitely.
  - out_valid never drops before the take.
- Simultaneous in_valid and in_last on the first word: len=1; the first DRAIN cycle has out_last=1.
- in_last on the word at wr_ptr==DEPTH-1: a single transition, identical to the full case.
- Reset asserted mid-frame or mid-drain:
  - Immediate return to LOAD with pointers, len and array at 0.
  - out_valid falls without waiting for clk.
  - The partial frame is discarded.

## Test plan
- Reset, then load 1,3,5,7 (DEPTH=4, no in_last) with out_ready=1 -> out_data 1,3,5,7 on consecutive cycles. out_last=1 only on 7. in_ready=0 for exactly those 4 cycles. count reads 4,3,2,1 during drain.
- Load 9 then 11 with in_last on 11 -> count=2, out_data 9 then 11, out_last on 11. The stale entries 5,7 from the previous frame are never output.
- Single word 42 with in_last -> one DRAIN cycle, out_data=42 with out_last=1, and in_ready returns the following cycle.
- Drain 1,3,5,7 with out_ready low for 3 cycles after word 3 -> out_data stays 3 and out_valid stays 1 throughout the stall. The remaining order is unchanged.
- Hold in_valid=1 with data 99 throughout DRAIN -> no write occurs and the drained frame is unaltered. The next frame's first accepted word is the one presented after in_ready rises.
- Assert reset between the 2nd and 3rd drain handshakes -> out_valid=0 and count=0 immediately. After release, in_ready=1 and a new 4-word frame drains correctly.
